// File: rtl/fft_ctrl_pkg.sv
// Shared state type and frame-geometry helpers for the FFT stage controllers.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stage_state_e;

  function automatic int nblk(input int frame_len, input int depth);
    return frame_len / depth;
  endfunction

  function automatic bit frame_len_ok(input int frame_len, input int depth);
    return (depth > 0) && ((frame_len % depth) == 0);
  endfunction

endpackage

// File: rtl/mul_fac_stage_ctrl.sv
// Sequencer for one twiddle-multiply stage: accepts a frame as NBLK blocks,
// drives the multiplier enable/ROM address and streams its registered output.
module mul_fac_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int FRAME_LEN  = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int ADDR_BASE  = 0,
  parameter int ADDR_STEP  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mul_en,
  output logic [ADDR_WIDTH-1:0] mul_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NBLK = nblk(FRAME_LEN, DEPTH);
  localparam int CW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [CW-1:0] LAST_BLK = CW'(NBLK - 1);

  if (!frame_len_ok(FRAME_LEN, DEPTH)) begin : g_bad_frame_len
    $error("mul_fac_stage_ctrl: FRAME_LEN must be a multiple of DEPTH");
  end

  stage_state_e  state_q, state_d;
  logic [CW-1:0] blk_cnt_q, blk_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          in_ready_s;
  logic          fire_s;
  logic          is_last_s;

  assign is_last_s = (blk_cnt_q == LAST_BLK);

  // Next-state and handshake logic; the multiplier register is the only storage.
  always_comb begin
    state_d     = state_q;
    blk_cnt_d   = blk_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = err_q;
    in_ready_s  = 1'b0;
    fire_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          blk_cnt_d = '0;
          err_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        in_ready_s = !out_valid_q || out_ready;
        fire_s     = in_valid && in_ready_s;
        if (fire_s) begin
          out_valid_d = 1'b1;
          out_last_d  = is_last_s;
          if (in_last != is_last_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (is_last_s) begin
            blk_cnt_d = '0;
            state_d   = DRAIN;
          end else begin
            blk_cnt_d = blk_cnt_q + CW'(1);
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_cnt_q   <= blk_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Address comes from the registered count so it is stable before mul_en rises.
  assign mul_addr  = ADDR_WIDTH'(ADDR_BASE + int'(blk_cnt_q) * ADDR_STEP);
  assign in_ready  = in_ready_s;
  assign mul_en    = fire_s;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mul_fac_stage_ctrl.sv
// Directed bench for mul_fac_stage_ctrl: a default-address instance and an
// offset instance (base 500) share stimulus so ROM address wrap is checked too.
module tb_mul_fac_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_last, out_ready;
  logic       in_ready, mul_en, out_valid, out_last, busy, done, err;
  logic [8:0] mul_addr;
  logic       b_in_ready, b_mul_en, b_out_valid, b_out_last, b_busy, b_done, b_err;
  logic [8:0] b_mul_addr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mul_fac_stage_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mul_en(mul_en), .mul_addr(mul_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  mul_fac_stage_ctrl #(.ADDR_BASE(500), .ADDR_STEP(16)) dut_off (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .in_ready(b_in_ready), .mul_en(b_mul_en), .mul_addr(b_mul_addr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_last(b_out_last),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame with optional downstream stall (5 cycles at block stall_at) and
  // in_last placed on block last_at; a small occupancy model predicts handshakes.
  task automatic run_frame(input int stall_at, input int last_at, input bit exp_err_end);
    int  k = 0;
    int  nout = 0;
    int  stall = 0;
    int  cyc = 0;
    bit  exp_ov = 1'b0;
    bit  exp_olast = 1'b0;
    bit  exp_err = 1'b0;
    bit  finished = 1'b0;
    bit  exp_ready, fire, acc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!finished && cyc < 300) begin
      in_valid  = (k < 32);
      in_last   = (k == last_at);
      out_ready = !(k == stall_at && stall < 5);
      #1;
      exp_ready = (k < 32) && (!exp_ov || out_ready);
      chk("in_ready", in_ready, exp_ready);
      chk("mul_en", mul_en, in_valid && exp_ready);
      chk("mul_addr", mul_addr, (16 * (k % 32)) % 512);
      chk("mul_addr_off", b_mul_addr, (500 + 16 * (k % 32)) % 512);
      chk("out_valid", out_valid, exp_ov);
      chk("out_last", out_last, exp_ov && exp_olast);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("err_run", err, exp_err);
      fire = in_valid && exp_ready;
      acc  = exp_ov && out_ready;
      if (!out_ready) stall++;
      if (acc) begin
        nout++;
        if (exp_olast) finished = 1'b1;
      end
      if (fire) begin
        if ((k == last_at) != (k == 31)) exp_err = 1'b1;
        exp_ov    = 1'b1;
        exp_olast = (k == 31);
        k++;
      end else if (acc) begin
        exp_ov = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("frame_timeout", finished, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    chk("done_pulse", done, 1);
    chk("busy_idle", busy, 0);
    chk("out_valid_idle", out_valid, 0);
    chk("err_end", err, exp_err_end);
    chk("blocks_out", nout, 32);
    tick();
    chk("done_once", done, 0);
    chk("err_sticky", err, exp_err_end);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;

    // T1: reset, then in_valid without start is never accepted.
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mul_en", mul_en, 0);
    chk("rst_mul_addr", mul_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_in_ready", in_ready, 0);
      chk("idle_mul_en", mul_en, 0);
      chk("idle_busy", busy, 0);
    end
    in_valid = 1'b0;
    tick();

    // T2 + T4: full-rate frame, offset instance wraps its addresses.
    run_frame(-1, 31, 1'b0);

    // T5: in_last on block 10 -> sticky err to end of frame.
    run_frame(-1, 10, 1'b1);

    // T3: 5-cycle downstream stall mid-frame; start also clears err.
    run_frame(10, 31, 1'b0);

    // T6: reset at block 7 aborts the frame without done.
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("abort_mul_addr", mul_addr, 16 * i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_in_ready", in_ready, 0);
    tick();
    chk("abort_no_done", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("restart_busy", busy, 1);
    chk("restart_mul_addr", mul_addr, 0);
    chk("restart_mul_addr_off", b_mul_addr, 500);
    in_valid = 1'b1;
    #1;
    chk("restart_mul_en", mul_en, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
